cic_dec_ctrl: RTL and testbench

//  Sequencer for the single-section CIC decimator datapath.
//  - Drives the integrator clock-enable, the comb/output-register phase strobe and a one-cycle state clear.
//  - Replaces the fixed divide-by-5 counter with a runtime-programmable rate R, changed only at frame boundaries.
//  - Adds start/stop control with a clean drain, and a valid/ready handshake plus overrun detection on the decimated output.

---
 rtl/cic_dec_ctrl.sv | 137 +++++++++++++
 tb/tb_cic_dec_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cic_dec_ctrl.sv
// Sequencer for a single-section CIC decimator: integrator enable, comb phase strobe,
// state clear, programmable rate, start/stop with drain, and an output valid/ready handshake.
// Optional frame counter: define CIC_CTRL_FRAME_CNT_EN; otherwise frame_cnt is tied to zero.
module cic_dec_ctrl #(
    parameter int CNT_W        = 4,
    parameter int RATE_MIN     = 2,
    parameter int RATE_DEFAULT = 5
) (
    input  logic             clk,
    input  logic             syn_rst,
    input  logic             clk_enable,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_rate,
    input  logic             cfg_load,
    output logic             cfg_err,
    output logic             flush_clr,
    output logic             integ_en,
    output logic             comb_phase,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam logic [CNT_W-1:0] RATE_MIN_V     = CNT_W'(RATE_MIN);
    localparam logic [CNT_W-1:0] RATE_DEFAULT_V = CNT_W'(RATE_DEFAULT);
    localparam logic [CNT_W-1:0] ONE_V          = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cur_count_reg;
    logic [CNT_W-1:0] active_rate_reg;
    logic [CNT_W-1:0] pending_rate_reg;
    logic             cfg_err_reg;
    logic             out_valid_reg;
    logic             overrun_reg;
    logic             rate_ok;
    logic             count_wrap;

    assign rate_ok    = (cfg_rate >= RATE_MIN_V);
    assign count_wrap = (cur_count_reg == (active_rate_reg - ONE_V));

    always_comb begin
        state_next = state_reg;
        integ_en   = 1'b0;
        comb_phase = 1'b0;
        flush_clr  = 1'b0;
        busy       = (state_reg != ST_IDLE);

        integ_en   = ((state_reg == ST_RUN) || (state_reg == ST_DRAIN)) && clk_enable;
        comb_phase = integ_en && (cur_count_reg == '0);
        flush_clr  = (state_reg == ST_CLEAR);

        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_RUN;
            ST_RUN: begin
                // A stop landing on a phase cycle finishes the frame right here.
                if (stop) state_next = comb_phase ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: if (comb_phase) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            cur_count_reg    <= '0;
            active_rate_reg  <= RATE_DEFAULT_V;
            pending_rate_reg <= RATE_DEFAULT_V;
            cfg_err_reg      <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_load && !rate_ok;
            if (cfg_load && rate_ok) pending_rate_reg <= cfg_rate;

            if (flush_clr) begin
                cur_count_reg   <= '0;
                active_rate_reg <= pending_rate_reg;
            end else if (integ_en) begin
                cur_count_reg <= count_wrap ? '0 : cur_count_reg + ONE_V;
                // New rate takes effect only at a frame boundary.
                if (comb_phase) active_rate_reg <= pending_rate_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (syn_rst || flush_clr) begin
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else if (comb_phase) begin
            // An unaccepted sample is overwritten by the new one.
            if (out_valid_reg && !out_ready) overrun_reg <= 1'b1;
            out_valid_reg <= 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign cfg_err   = cfg_err_reg;
    assign out_valid = out_valid_reg;
    assign overrun   = overrun_reg;

`ifdef CIC_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (syn_rst || flush_clr) begin
            frame_cnt_reg <= 16'd0;
        end else if (comb_phase) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Bench for cic_dec_ctrl: directed scenarios followed by random stimulus, each cycle
// checked against a behavioural model of the sequencer built from frame position arithmetic.
module tb_cic_dec_ctrl;

    logic        clk = 1'b0;
    logic        syn_rst = 1'b1;
    logic        clk_enable = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  cfg_rate = 4'd0;
    logic        cfg_load = 1'b0;
    logic        cfg_err;
    logic        flush_clr;
    logic        integ_en;
    logic        comb_phase;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overrun;
    logic        busy;
    logic [15:0] frame_cnt;

    cic_dec_ctrl #(
        .CNT_W        (4),
        .RATE_MIN     (2),
        .RATE_DEFAULT (5)
    ) dut (
        .clk        (clk),
        .syn_rst    (syn_rst),
        .clk_enable (clk_enable),
        .start      (start),
        .stop       (stop),
        .cfg_rate   (cfg_rate),
        .cfg_load   (cfg_load),
        .cfg_err    (cfg_err),
        .flush_clr  (flush_clr),
        .integ_en   (integ_en),
        .comb_phase (comb_phase),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    bit armed = 1'b0;

    // Model: mode 0 idle, 1 clear, 2 run, 3 drain; pos = enables since frame start mod rate.
    int m_mode, m_pos, m_rate, m_pend, m_frames;
    bit m_ov, m_ovf, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit ce, input bit st, input bit sp,
                        input int rt, input bit ld, input bit rdy);
        bit ie, cp, fc, bz;
        @(negedge clk);
        syn_rst    = r;
        clk_enable = ce;
        start      = st;
        stop       = sp;
        cfg_rate   = rt[3:0];
        cfg_load   = ld;
        out_ready  = rdy;
        #1;
        bz = (m_mode != 0);
        ie = (m_mode == 2 || m_mode == 3) && ce;
        cp = ie && (m_pos == 0);
        fc = (m_mode == 1);
        if (armed) begin
            check("flush_clr", 32'(flush_clr), 32'(fc));
            check("integ_en", 32'(integ_en), 32'(ie));
            check("comb_phase", 32'(comb_phase), 32'(cp));
            check("busy", 32'(busy), 32'(bz));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("overrun", 32'(overrun), 32'(m_ovf));
            check("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef CIC_CTRL_FRAME_CNT_EN
            check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
`else
            check("frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        end
        if (r) begin
            m_mode = 0; m_pos = 0; m_rate = 5; m_pend = 5; m_frames = 0;
            m_ov = 0; m_ovf = 0; m_err = 0;
        end else begin
            m_err = ld && (rt < 2);
            case (m_mode)
                0: if (st) m_mode = 1;
                1: begin m_mode = 2; m_pos = 0; m_rate = m_pend; end
                2: if (sp) m_mode = cp ? 0 : 3;
                default: if (cp) m_mode = 0;
            endcase
            if (ie) begin
                m_pos = (m_pos + 1) % m_rate;
                if (cp) m_rate = m_pend;
            end
            if (fc) begin
                m_ov = 0; m_ovf = 0;
            end else if (cp) begin
                if (m_ov && !rdy) m_ovf = 1;
                m_ov = 1;
            end else if (m_ov && rdy) begin
                m_ov = 0;
            end
            if (fc) m_frames = 0;
            else if (cp) m_frames = (m_frames + 1) % 65536;
            if (ld && rt >= 2) m_pend = rt;
        end
        @(posedge clk);
        cyc++;
        armed = 1'b1;
    endtask

    task automatic run(input int n, input bit ce_alt, input bit rdy);
        for (int i = 0; i < n; i++) step(0, ce_alt ? bit'(i % 2 == 0) : 1'b1, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        // Reset, then default rate 5 with continuous enables
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1);
        run(12, 0, 1);
        // Mid-frame rate load of 3
        step(0, 1, 0, 0, 3, 1, 1);
        run(12, 0, 1);
        // Rate 4 with 1-in-2 enables
        step(0, 1, 0, 1, 4, 1, 1);
        run(8, 0, 1);
        step(0, 0, 1, 0, 0, 0, 1);
        run(20, 1, 1);
        // Downstream stalled across two phases, then restart clears overrun
        run(12, 0, 0);
        step(0, 1, 0, 1, 5, 1, 0);
        run(6, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        run(7, 0, 1);
        // Stop mid-frame (drain), restart, stop on a phase
        step(0, 1, 0, 1, 0, 0, 1);
        run(6, 0, 1);
        step(0, 1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 1, 0, 0, 1);
        run(3, 0, 1);
        // Rejected rates and a mid-frame reset
        step(0, 1, 0, 0, 1, 1, 1);
        step(0, 1, 0, 0, 0, 1, 1);
        step(0, 1, 1, 0, 0, 0, 1);
        run(4, 0, 1);
        step(1, 1, 1, 1, 0, 0, 1);
        run(3, 0, 1);

        for (int blk = 0; blk < 6; blk++) begin
            int rdy_pct = 20 + blk * 15;
            int ce_pct  = 30 + blk * 12;
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(199) == 0,
                     $urandom_range(99) < ce_pct,
                     $urandom_range(7) == 0,
                     $urandom_range(15) == 0,
                     int'($urandom_range(15)),
                     $urandom_range(9) == 0,
                     $urandom_range(99) < rdy_pct);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
